// File: rtl/dlatch_ctrl_pkg.sv
// Shared types and default timing for the D-latch bank write controller.
// Imported by the RTL and by the bench.
package dlatch_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SETUP = 3'd1,
        OPEN  = 3'd2,
        HOLD  = 3'd3,
        DONE  = 3'd4,
        FLUSH = 3'd5
    } ctrl_state_e;

    localparam int DEF_N_LATCH   = 8;
    localparam int DEF_DW        = 1;
    localparam int DEF_SETUP_CYC = 1;
    localparam int DEF_OPEN_CYC  = 2;
    localparam int DEF_HOLD_CYC  = 1;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/dlatch_phase_timer.sv
// Loadable down-counter shared by the setup, open and hold phases.
// tc is high while the count sits at zero, i.e. on the last cycle of a phase.
module dlatch_phase_timer #(
    parameter int CW = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          load,
    input  logic [CW-1:0] load_val,
    output logic          tc
);

    logic [CW-1:0] cnt_r;

    // Phase counter: reload on phase entry, otherwise count down to zero and stop
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r <= {CW{1'b0}};
        end else if (load) begin
            cnt_r <= load_val;
        end else if (cnt_r != {CW{1'b0}}) begin
            cnt_r <= cnt_r - {{(CW-1){1'b0}}, 1'b1};
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign tc = (cnt_r == {CW{1'b0}});

endmodule

// File: rtl/dlatch_bank_ctrl.sv
// Write sequencer for a bank of level-sensitive D latches on a shared data bus:
// setup, one-hot enable pulse, hold; plus a flush that walks every latch.
module dlatch_bank_ctrl
    import dlatch_ctrl_pkg::*;
#(
    parameter int            N_LATCH   = DEF_N_LATCH,
    parameter int            DW        = DEF_DW,
    parameter int            SETUP_CYC = DEF_SETUP_CYC,
    parameter int            OPEN_CYC  = DEF_OPEN_CYC,
    parameter int            HOLD_CYC  = DEF_HOLD_CYC,
    parameter logic [DW-1:0] FLUSH_VAL = '0
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       req_valid,
    output logic                       req_ready,
    input  logic [$clog2(N_LATCH)-1:0] req_idx,
    input  logic [DW-1:0]              req_data,
    input  logic                       flush_req,
    output logic                       flush_busy,
    output logic [DW-1:0]              lat_d,
    output logic [N_LATCH-1:0]         lat_en,
    output logic                       done,
    output logic                       err
);

    localparam int IW = $clog2(N_LATCH);
    localparam int CW = $clog2(max3(SETUP_CYC, OPEN_CYC, HOLD_CYC) + 1);

    ctrl_state_e        state_r, nxt_state_s;
    logic [IW-1:0]      idx_r, nxt_idx_s;
    logic [DW-1:0]      lat_d_r, nxt_lat_d_s;
    logic [N_LATCH-1:0] lat_en_r, en_dec_s;
    logic               flush_r, nxt_flush_s;
    logic               ready_r, done_r, err_r, nxt_err_s;
    logic               tc_s, load_s, idx_ok_s, accept_s, flush_start_s, req_ready_s;
    logic [CW-1:0]      load_val_s;

    // Flush must win over a simultaneous request, so ready is gated combinationally.
    assign req_ready_s   = ready_r & ~flush_req;
    assign accept_s      = req_valid & req_ready_s;
    assign flush_start_s = ready_r & flush_req;
    assign idx_ok_s      = ({1'b0, req_idx} < (IW+1)'(N_LATCH));

    // Next-state, index and data selection
    always_comb begin
        nxt_state_s = state_r;
        nxt_idx_s   = idx_r;
        nxt_lat_d_s = lat_d_r;
        nxt_flush_s = flush_r;
        nxt_err_s   = 1'b0;
        case (state_r)
            IDLE: begin
                if (flush_start_s) begin
                    nxt_flush_s = 1'b1;
                    nxt_idx_s   = {IW{1'b0}};
                    nxt_lat_d_s = FLUSH_VAL;
                    nxt_state_s = SETUP;
                end else if (accept_s) begin
                    if (idx_ok_s) begin
                        nxt_flush_s = 1'b0;
                        nxt_idx_s   = req_idx;
                        nxt_lat_d_s = req_data;
                        nxt_state_s = SETUP;
                    end else begin
                        nxt_err_s   = 1'b1;
                    end
                end else begin
                    nxt_state_s = IDLE;
                end
            end
            SETUP: begin
                if (tc_s) nxt_state_s = OPEN;
                else      nxt_state_s = SETUP;
            end
            OPEN: begin
                if (tc_s) nxt_state_s = HOLD;
                else      nxt_state_s = OPEN;
            end
            HOLD: begin
                if (tc_s) begin
                    if (flush_r && (idx_r != IW'(N_LATCH - 1))) begin
                        nxt_idx_s   = idx_r + {{(IW-1){1'b0}}, 1'b1};
                        nxt_state_s = SETUP;
                    end else begin
                        nxt_state_s = DONE;
                    end
                end else begin
                    nxt_state_s = HOLD;
                end
            end
            DONE: begin
                nxt_flush_s = 1'b0;
                nxt_state_s = IDLE;
            end
            default: begin
                nxt_flush_s = 1'b0;
                nxt_state_s = IDLE;
            end
        endcase
    end

    // Phase length for the state being entered; any state change reloads the timer
    always_comb begin
        load_s = (nxt_state_s != state_r);
        case (nxt_state_s)
            SETUP:   load_val_s = CW'(SETUP_CYC - 1);
            OPEN:    load_val_s = CW'(OPEN_CYC - 1);
            HOLD:    load_val_s = CW'(HOLD_CYC - 1);
            default: load_val_s = {CW{1'b0}};
        endcase
    end

    // One-hot decode of the selected latch
    always_comb begin
        en_dec_s = {N_LATCH{1'b0}};
        for (int i = 0; i < N_LATCH; i++) begin
            en_dec_s[i] = (idx_r == IW'(i));
        end
    end

    dlatch_phase_timer #(.CW(CW)) u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (load_s),
        .load_val (load_val_s),
        .tc       (tc_s)
    );

    // State and registered outputs; outputs follow the state being entered so they
    // line up with it. lat_d only moves on entry to SETUP, when every enable is low.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r  <= IDLE;
            idx_r    <= {IW{1'b0}};
            flush_r  <= 1'b0;
            ready_r  <= 1'b0;
            lat_d_r  <= {DW{1'b0}};
            lat_en_r <= {N_LATCH{1'b0}};
            done_r   <= 1'b0;
            err_r    <= 1'b0;
        end else begin
            state_r  <= nxt_state_s;
            idx_r    <= nxt_idx_s;
            flush_r  <= nxt_flush_s;
            ready_r  <= (nxt_state_s == IDLE);
            lat_d_r  <= nxt_lat_d_s;
            lat_en_r <= (nxt_state_s == OPEN) ? en_dec_s : {N_LATCH{1'b0}};
            done_r   <= (nxt_state_s == DONE);
            err_r    <= nxt_err_s;
        end
    end

    assign req_ready  = req_ready_s;
    assign flush_busy = flush_r;
    assign lat_d      = lat_d_r;
    assign lat_en     = lat_en_r;
    assign done       = done_r;
    assign err        = err_r;

endmodule

// File: tb/tb_dlatch_bank_ctrl.sv
// Bench for dlatch_bank_ctrl: directed writes/flushes with a scoreboard of expected
// done/err events, latch models on the bank, and per-cycle bus invariants.
module tb_dlatch_bank_ctrl;
    import dlatch_ctrl_pkg::*;

    localparam int N8 = 8;
    localparam int N6 = 6;
    localparam int K_DONE = 0;
    localparam int K_ERR  = 1;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    logic          req_valid = 1'b0, req_ready, flush_req = 1'b0, flush_busy, done, err;
    logic [2:0]    req_idx = 3'd0;
    logic [0:0]    req_data = 1'b0, lat_d;
    logic [N8-1:0] lat_en;

    logic          req_valid6 = 1'b0, req_ready6, flush_busy6, done6, err6;
    logic [2:0]    req_idx6 = 3'd0;
    logic [0:0]    req_data6 = 1'b0, lat_d6;
    logic [N6-1:0] lat_en6;

    dlatch_bank_ctrl #(.N_LATCH(N8)) u_dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
        .req_idx(req_idx), .req_data(req_data), .flush_req(flush_req),
        .flush_busy(flush_busy), .lat_d(lat_d), .lat_en(lat_en), .done(done), .err(err)
    );

    dlatch_bank_ctrl #(.N_LATCH(N6)) u_dut6 (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid6), .req_ready(req_ready6),
        .req_idx(req_idx6), .req_data(req_data6), .flush_req(1'b0),
        .flush_busy(flush_busy6), .lat_d(lat_d6), .lat_en(lat_en6), .done(done6), .err(err6)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural D latches on the bank
    logic [N8-1:0] q8;
    logic [N6-1:0] q6;
    always_latch begin
        for (int i = 0; i < N8; i++) if (lat_en[i]) q8[i] = lat_d[0];
    end
    always_latch begin
        for (int i = 0; i < N6; i++) if (lat_en6[i]) q6[i] = lat_d6[0];
    end

    int n_checks = 0;
    int n_errors = 0;

    typedef struct { int kind; int cyc; } exp_t;
    exp_t sb8[$];
    exp_t sb6[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s actual=%0h required=%0h (cyc %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic pop8(input int k);
        exp_t e;
        if (sb8.size() == 0) begin
            n_checks++; n_errors++;
            $display("FAIL evt8_unexpected actual=kind%0d@%0d required=none", k, cyc);
        end else begin
            e = sb8.pop_front();
            check("evt8_kind", k, e.kind);
            check("evt8_cyc", cyc, e.cyc);
        end
    endtask

    task automatic pop6(input int k);
        exp_t e;
        if (sb6.size() == 0) begin
            n_checks++; n_errors++;
            $display("FAIL evt6_unexpected actual=kind%0d@%0d required=none", k, cyc);
        end else begin
            e = sb6.pop_front();
            check("evt6_kind", k, e.kind);
            check("evt6_cyc", cyc, e.cyc);
        end
    endtask

    // Monitor: retire scoreboard events and check bus invariants every cycle
    logic prev_done = 1'b0;
    logic [0:0] prev_lat_d = 1'b0;
    always @(negedge clk) begin
        if (rst_n) begin
            if (done)  pop8(K_DONE);
            if (err)   pop8(K_ERR);
            if (done6) pop6(K_DONE);
            if (err6)  pop6(K_ERR);
            check("onehot0_en", {31'd0, $onehot0(lat_en)}, 32'd1);
            if (|lat_en) check("lat_d_stable", lat_d, prev_lat_d);
            if (done && prev_done) check("done_width", 32'd2, 32'd1);
        end
        prev_done  = done;
        prev_lat_d = lat_d;
    end

    task automatic write8(input logic [2:0] idx, input logic d, input bit push, output int waits);
        int a;
        waits = 0;
        @(negedge clk);
        req_valid = 1'b1; req_idx = idx; req_data = d;
        #1;
        while (!req_ready && waits < 100) begin
            @(negedge clk); #1;
            waits++;
        end
        if (!req_ready) begin
            n_checks++; n_errors++;
            $display("FAIL accept_timeout actual=no_ready required=ready");
        end else begin
            a = cyc;
            if (push) sb8.push_back('{K_DONE, a + 5});
            @(posedge clk);
        end
    endtask

    task automatic drop8();
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic wait_idle8();
        int n;
        n = 0;
        @(negedge clk); #1;
        while (!req_ready && n < 100) begin
            @(negedge clk); #1;
            n++;
        end
        if (!req_ready) begin
            n_checks++; n_errors++;
            $display("FAIL idle_timeout actual=busy required=idle");
        end
    endtask

    logic [N8-1:0] exp_en [1:5];
    int w, a, n;

    initial begin
        exp_en[1] = 8'h00; exp_en[2] = 8'h08; exp_en[3] = 8'h08; exp_en[4] = 8'h00; exp_en[5] = 8'h00;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_lat_en", lat_en, 32'h0);
        check("rst_lat_d", lat_d, 32'h0);
        check("rst_ready", req_ready, 32'h0);
        check("rst_done", done, 32'h0);
        check("rst_err", err, 32'h0);
        check("rst_busy", flush_busy, 32'h0);
        rst_n = 1'b1;
        @(negedge clk); #1;
        check("post_rst_ready", req_ready, 32'h1);

        // Initial flush puts the bank in a known state
        @(negedge clk);
        flush_req = 1'b1;
        #1;
        check("flush_gates_ready", req_ready, 32'h0);
        a = cyc;
        sb8.push_back('{K_DONE, a + 33});
        @(negedge clk);
        flush_req = 1'b0;
        check("flush_busy_set", flush_busy, 32'h1);
        wait_idle8();
        check("flush0_q", q8, 32'h00);

        // Single write idx 3
        write8(3'd3, 1'b1, 1'b1, w);
        check("wr3_no_wait", w, 32'd0);
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk); #1;
            if (k == 1) req_valid = 1'b0;
            check("wr3_en_timing", lat_en, exp_en[k]);
        end
        wait_idle8();
        check("wr3_q", q8, 32'h08);

        // Back-to-back with req_valid held
        write8(3'd0, 1'b1, 1'b1, w);
        write8(3'd7, 1'b1, 1'b1, w);
        check("b2b_ready_low_cycles", w, 32'd5);
        drop8();
        wait_idle8();
        check("b2b_q", q8, 32'h89);

        // Flush and request in the same cycle: flush wins, request follows
        @(negedge clk);
        flush_req = 1'b1; req_valid = 1'b1; req_idx = 3'd5; req_data = 1'b1;
        #1;
        check("flush_pri_ready", req_ready, 32'h0);
        a = cyc;
        sb8.push_back('{K_DONE, a + 33});
        @(negedge clk);
        flush_req = 1'b0;
        check("flush_pri_busy", flush_busy, 32'h1);
        write8(3'd5, 1'b1, 1'b1, w);
        check("flush_pri_wait", w, 32'd32);
        check("flush_pri_busy_clr", flush_busy, 32'h0);
        check("flush_pri_q", q8, 32'h00);
        drop8();
        wait_idle8();
        check("post_flush_wr5_q", q8, 32'h20);

        // Out-of-range index on the 6-latch bank
        @(negedge clk);
        req_valid6 = 1'b1; req_idx6 = 3'd6; req_data6 = 1'b1;
        #1;
        check("oor_ready", req_ready6, 32'h1);
        a = cyc;
        sb6.push_back('{K_ERR, a + 1});
        @(negedge clk);
        req_valid6 = 1'b0;
        for (int k = 0; k < 4; k++) begin
            check("oor_no_en", lat_en6, 32'h0);
            check("oor_stay_idle", req_ready6, 32'h1);
            @(negedge clk);
        end
        req_valid6 = 1'b1; req_idx6 = 3'd5; req_data6 = 1'b1;
        #1;
        check("n6_wr5_ready", req_ready6, 32'h1);
        a = cyc;
        sb6.push_back('{K_DONE, a + 5});
        @(negedge clk);
        req_valid6 = 1'b0;
        repeat (6) @(negedge clk);
        check("n6_wr5_q", q6[5], 32'h1);

        // Reset during OPEN: enables drop at once, the write is lost
        write8(3'd2, 1'b1, 1'b0, w);
        drop8();
        n = 0;
        while (lat_en == 8'h00 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("reached_open", lat_en, 32'h04);
        rst_n = 1'b0;
        #1;
        check("async_rst_en", lat_en, 32'h0);
        check("async_rst_d", lat_d, 32'h0);
        @(negedge clk);
        check("in_rst_ready", req_ready, 32'h0);
        check("in_rst_done", done, 32'h0);
        rst_n = 1'b1;
        @(negedge clk); #1;
        check("rst_rel_ready", req_ready, 32'h1);
        check("rst_rel_done", done, 32'h0);
        repeat (8) @(negedge clk);

        n = 0;
        while ((sb8.size() != 0 || sb6.size() != 0) && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("sb8_drained", sb8.size(), 32'd0);
        check("sb6_drained", sb6.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
